// File: rtl/fa_bist.sv
// Self-test sequencer for a 1-bit full adder: walks all eight {A,B,Cin} vectors,
// checks sum/carry after a settle delay and reports verdict, error count and first failure.
module fa_bist #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iStart,
  output logic       oA,
  output logic       oB,
  output logic       oCi,
  input  logic       iS,
  input  logic       iCo,
  output logic       oBusy,
  output logic       oDone,
  output logic       oPass,
  output logic [3:0] oErrCnt,
  output logic [2:0] oFailVec,
  output logic       oFailValid
);

  typedef enum logic [1:0] {st_idle, st_drive, st_check, st_done} state_t;

  localparam logic [3:0] LastCnt = 4'(SETTLE - 1);

  state_t     state;
  logic [2:0] vec;
  logic [3:0] cnt;
  logic       exp_s;
  logic       exp_co;
  logic       mismatch;

  // Stimulus comes straight from the vector register, so it is glitch-free.
  assign {oA, oB, oCi} = vec;

  always_comb begin
    exp_s    = ^vec;
    exp_co   = (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]);
    mismatch = (iS != exp_s) || (iCo != exp_co);
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state      <= st_idle;
      vec        <= 3'b000;
      cnt        <= 4'd0;
      oBusy      <= 1'b0;
      oDone      <= 1'b0;
      oPass      <= 1'b0;
      oErrCnt    <= 4'd0;
      oFailVec   <= 3'b000;
      oFailValid <= 1'b0;
    end else begin
      unique case (state)
        st_idle: begin
          vec   <= 3'b000;
          oBusy <= 1'b0;
          oDone <= 1'b0;
          if (iStart) begin
            state      <= st_drive;
            oBusy      <= 1'b1;
            cnt        <= 4'd0;
            oErrCnt    <= 4'd0;
            oFailVec   <= 3'b000;
            oFailValid <= 1'b0;
            oPass      <= 1'b0;
          end
        end
        st_drive: begin
          if (cnt == LastCnt) begin
            state <= st_check;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        st_check: begin
          if (mismatch) begin
            oErrCnt <= oErrCnt + 4'd1;
            if (!oFailValid) begin
              oFailVec   <= vec;
              oFailValid <= 1'b1;
            end
          end
          if (vec == 3'b111) begin
            state <= st_done;
            oBusy <= 1'b0;
            oDone <= 1'b1;
            // Verdict must include a mismatch found in this final check.
            oPass <= !mismatch && (oErrCnt == 4'd0);
            vec   <= 3'b000;
          end else begin
            state <= st_drive;
            vec   <= vec + 3'd1;
            cnt   <= 4'd0;
          end
        end
        st_done: begin
          oDone <= 1'b0;
          state <= st_idle;
        end
        default: state <= st_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_fa_bist.sv
// Bench for fa_bist: two instances (SETTLE=2 and SETTLE=1) driving a faultable adder,
// checked every cycle against a cycle-index model plus literal expectations.
module tb_fa_bist;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] fault;  // 0 good, 1 carry stuck at 0, 2 sum inverted
  logic [1:0] a, b, ci, s, co, busy, done, pass, fvld;
  logic [3:0] err [2];
  logic [2:0] fv  [2];

  int checks = 0;
  int errors = 0;

  // Modelled state: edges since the accepting edge (-1 = idle) and held results.
  int n_m    [2];
  int h_err  [2];
  int h_fv   [2];
  int h_fvld [2];
  int h_pass [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign s  = a ^ b ^ ci ^ {2{fault == 2'd2}};
  assign co = (fault == 2'd1) ? 2'b00 : ((a & b) | (a & ci) | (b & ci));

  fa_bist #(.SETTLE(2)) u_dut2 (
    .iClk(clk), .iRst(rst), .iStart(start),
    .oA(a[0]), .oB(b[0]), .oCi(ci[0]), .iS(s[0]), .iCo(co[0]),
    .oBusy(busy[0]), .oDone(done[0]), .oPass(pass[0]),
    .oErrCnt(err[0]), .oFailVec(fv[0]), .oFailValid(fvld[0])
  );

  fa_bist #(.SETTLE(1)) u_dut1 (
    .iClk(clk), .iRst(rst), .iStart(start),
    .oA(a[1]), .oB(b[1]), .oCi(ci[1]), .iS(s[1]), .iCo(co[1]),
    .oBusy(busy[1]), .oDone(done[1]), .oPass(pass[1]),
    .oErrCnt(err[1]), .oFailVec(fv[1]), .oFailValid(fvld[1])
  );

  task automatic chk(input string name, input int inst, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s inst%0d got=%0d exp=%0d at %0t", name, inst, got, exp, $time);
    end
  endtask

  function automatic int settle_of(input int inst);
    return (inst == 0) ? 2 : 1;
  endfunction

  // Does the faulty adder answer vector k wrongly?  Arithmetic reference.
  function automatic bit vec_bad(input int k, input int f);
    int tot, rs, rco;
    tot = ((k >> 2) & 1) + ((k >> 1) & 1) + (k & 1);
    rs  = (f == 2) ? 1 - (tot % 2) : tot % 2;
    rco = (f == 1) ? 0 : tot / 2;
    return (rs != tot % 2) || (rco != tot / 2);
  endfunction

  function automatic int nbad(input int n, input int st, input int f);
    int c = 0;
    for (int k = 0; k < 8; k++) if ((k + 1) * (st + 1) <= n && vec_bad(k, f)) c++;
    return c;
  endfunction

  function automatic int firstbad(input int n, input int st, input int f);
    for (int k = 0; k < 8; k++) if ((k + 1) * (st + 1) <= n && vec_bad(k, f)) return k;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        n_m[i]    <= -1;
        h_err[i]  <= 0;
        h_fv[i]   <= 0;
        h_fvld[i] <= 0;
        h_pass[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int st, len, fb;
        st  = settle_of(i);
        len = 8 * (st + 1);
        fb  = firstbad(len, st, int'(fault));
        if (n_m[i] < 0) begin
          if (start) n_m[i] <= 0;
        end else if (n_m[i] == len) begin
          n_m[i]    <= -1;
          h_err[i]  <= nbad(len, st, int'(fault));
          h_fv[i]   <= (fb < 0) ? 0 : fb;
          h_fvld[i] <= (fb >= 0) ? 1 : 0;
          h_pass[i] <= (nbad(len, st, int'(fault)) == 0) ? 1 : 0;
        end else begin
          n_m[i] <= n_m[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int st, len, nn, fb, e_err, e_fv, e_fvld, e_busy, e_done, e_pass, e_abc;
      bit chk_abc;
      st  = settle_of(i);
      len = 8 * (st + 1);
      nn  = n_m[i];
      if (nn < 0) begin
        e_busy = 0; e_done = 0; e_abc = 0; chk_abc = 1;
        e_err = h_err[i]; e_fv = h_fv[i]; e_fvld = h_fvld[i]; e_pass = h_pass[i];
      end else begin
        fb      = firstbad(nn, st, int'(fault));
        e_err   = nbad(nn, st, int'(fault));
        e_fv    = (fb < 0) ? 0 : fb;
        e_fvld  = (fb >= 0) ? 1 : 0;
        e_busy  = (nn < len) ? 1 : 0;
        e_done  = (nn == len) ? 1 : 0;
        e_pass  = (nn == len && e_err == 0) ? 1 : 0;
        chk_abc = (nn < len);
        e_abc   = nn / (st + 1);
      end
      chk("busy", i, int'(busy[i]), e_busy);
      chk("done", i, int'(done[i]), e_done);
      chk("errcnt", i, int'(err[i]), e_err);
      chk("failvec", i, int'(fv[i]), e_fv);
      chk("failvalid", i, int'(fvld[i]), e_fvld);
      chk("pass", i, int'(pass[i]), e_pass);
      if (chk_abc) chk("vector", i, int'({a[i], b[i], ci[i]}), e_abc);
    end
  end

  task automatic run_pulse(output int dc0, output int dc1);
    dc0 = 0;
    dc1 = 0;
    @(posedge clk); #1 start = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done[0] && dc0 == 0) dc0 = c + 1;
      if (done[1] && dc1 == 0) dc1 = c + 1;
    end
  endtask

  initial begin
    int d0, d1, ndone, waited;
    rst   = 1'b1;
    start = 1'b0;
    fault = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_outs", i, int'({a[i], b[i], ci[i], busy[i], done[i], pass[i], err[i], fv[i],
                                 fvld[i]}), 0);
    end
    #2 rst = 1'b0;

    // Good adder
    run_pulse(d0, d1);
    chk("good_done_cycle", 0, d0, 25);
    chk("good_done_cycle", 1, d1, 17);
    chk("good_pass", 0, int'(pass[0]), 1);
    chk("good_errcnt", 0, int'(err[0]), 0);
    chk("good_failvalid", 0, int'(fvld[0]), 0);
    chk("good_pass", 1, int'(pass[1]), 1);

    // Carry stuck at 0
    fault = 2'd1;
    run_pulse(d0, d1);
    chk("co0_errcnt", 0, int'(err[0]), 4);
    chk("co0_failvec", 0, int'(fv[0]), 3);
    chk("co0_failvalid", 0, int'(fvld[0]), 1);
    chk("co0_pass", 0, int'(pass[0]), 0);
    chk("co0_errcnt", 1, int'(err[1]), 4);

    // Sum inverted
    fault = 2'd2;
    run_pulse(d0, d1);
    chk("sinv_errcnt", 0, int'(err[0]), 8);
    chk("sinv_failvec", 0, int'(fv[0]), 0);
    chk("sinv_pass", 0, int'(pass[0]), 0);
    chk("sinv_errcnt", 1, int'(err[1]), 8);

    // Start held high: one done per run, restart after the IDLE cycle
    fault = 2'd0;
    @(posedge clk); #1 start = 1'b1;
    ndone = 0;
    for (int c = 0; c < 27; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        chk("held_clear_err", 0, int'(err[0]), 0);
        chk("held_clear_fvld", 0, int'(fvld[0]), 0);
      end
      if (c == 25) chk("held_idle_gap", 0, int'(busy[0]), 0);
      if (c < 26 && done[0]) ndone++;
    end
    chk("held_restart_busy", 0, int'(busy[0]), 1);
    chk("held_one_done", 0, ndone, 1);
    start  = 1'b0;
    waited = 0;
    while ((n_m[0] >= 0 || n_m[1] >= 0) && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("held_idle_timeout", 0, (waited < 100) ? 1 : 0, 1);

    // Asynchronous reset during vector 4
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    chk("mid_vec4", 0, int'({a[0], b[0], ci[0]}), 4);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("mid_rst_outs", i, int'({a[i], b[i], ci[i], busy[i], done[i], pass[i], err[i], fv[i],
                                   fvld[i]}), 0);
    end
    #10 rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done[0] || done[1]) ndone++;
    end
    chk("mid_no_done", 0, ndone, 0);
    run_pulse(d0, d1);
    chk("after_rst_done_cycle", 0, d0, 25);
    chk("after_rst_pass", 0, int'(pass[0]), 1);
    chk("after_rst_pass", 1, int'(pass[1]), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
